// File: rtl/plb_dac_stream_ul_if.sv
// PLB IPIF slave-side bus bundle for the DAC stream user logic.
// The bus signals keep their IPIF names and big-endian bit numbering (bit 31 = LSB).
interface plb_dac_stream_ul_if;
  logic [0:31] Bus2IP_Data;
  logic [0:3]  Bus2IP_BE;
  logic [0:3]  Bus2IP_RdCE;
  logic [0:3]  Bus2IP_WrCE;
  logic [0:31] IP2Bus_Data;
  logic        IP2Bus_RdAck;
  logic        IP2Bus_WrAck;
  logic        IP2Bus_Error;

  modport master (
    output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/plb_dac_stream_ul.sv
// PLB DAC user logic: sample FIFO drained round-robin over NUM_CH channels at a DIV+1 cycle rate.
// Optional DAC_STREAM_IRQ_EN adds a registered IP2Bus_IntrEvent (underrun or low-water).
module plb_dac_stream_ul #(
  parameter  int DAC_WIDTH  = 10,
  parameter  int NUM_CH     = 2,
  parameter  int FIFO_DEPTH = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 Bus2IP_Clk,
  input  logic                 Bus2IP_Reset,
  plb_dac_stream_ul_if.slave   bus,
  output logic [0:DAC_WIDTH-1] IP2DAC_Data,
  output logic [0:CH_W-1]      IP2DAC_Chan,
  output logic                 IP2DAC_Update
`ifdef DAC_STREAM_IRQ_EN
  ,
  output logic                 IP2Bus_IntrEvent
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef logic [DAC_WIDTH-1:0] sample_t;

  // Little-endian views of the bus words: wdata[0] is IPIF bit 31.
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic wr_ctrl, wr_div, wr_push, wr_clr_cnt;
  logic clr, tick, empty, full, pop, push, push_drop, underrun;

  sample_t             mem [FIFO_DEPTH];
  sample_t             head;

  logic                en_q,      en_d;
  logic                irq_en_q,  irq_en_d;
  logic [15:0]         div_q,     div_d;
  logic [15:0]         cnt_q,     cnt_d;
  logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [LVL_W-1:0]    level_q,   level_d;
  logic                und_q,     und_d;
  logic                ovf_q,     ovf_d;
  logic [15:0]         und_cnt_q, und_cnt_d;
  sample_t             dac_q,     dac_d;
  logic [CH_W-1:0]     chan_q,    chan_d;
  logic [CH_W-1:0]     nxt_ch_q,  nxt_ch_d;
  logic                upd_q,     upd_d;
  logic                intr_q,    intr_d;

  assign wdata      = bus.Bus2IP_Data;
  assign wr_ctrl    = bus.Bus2IP_WrCE[0];
  assign wr_div     = bus.Bus2IP_WrCE[1];
  assign wr_push    = bus.Bus2IP_WrCE[2];
  assign wr_clr_cnt = bus.Bus2IP_WrCE[3];

  assign head = mem[rd_ptr_q];

  // FIFO_CLR overrides both the pop and the push of the same cycle.
  always_comb begin
    clr       = wr_ctrl && wdata[1];
    empty     = (level_q == '0);
    full      = (level_q == LVL_W'(FIFO_DEPTH));
    tick      = en_q && (cnt_q == div_q);
    pop       = tick && !empty && !clr;
    underrun  = tick && empty && !clr;
    push      = wr_push && !clr && (!full || pop);
    push_drop = wr_push && !clr && full && !pop;
  end

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path can infer a latch.
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    und_d     = und_q;
    ovf_d     = ovf_q;
    und_cnt_d = und_cnt_q;
    dac_d     = dac_q;
    chan_d    = chan_q;
    nxt_ch_d  = nxt_ch_q;
    upd_d     = pop;

    if (wr_div || !en_q || tick) cnt_d = '0;
    else                         cnt_d = cnt_q + 16'd1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dac_d    = head;
      chan_d   = nxt_ch_q;
      nxt_ch_d = (nxt_ch_q == CH_W'(NUM_CH - 1)) ? '0 : nxt_ch_q + 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (push_drop) ovf_d = 1'b1;

    if (underrun) begin
      und_d = 1'b1;
      if (und_cnt_q != 16'hFFFF) und_cnt_d = und_cnt_q + 16'd1;
    end

    if (wr_clr_cnt) begin
      und_d     = 1'b0;
      ovf_d     = 1'b0;
      und_cnt_d = '0;
    end

    if (wr_ctrl) begin
      en_d     = wdata[0];
      irq_en_d = wdata[2];
      // A fresh enable restarts the channel sequence at 0.
      if (wdata[0] && !en_q) nxt_ch_d = '0;
    end

    if (wr_div) div_d = wdata[15:0];

    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      chan_d   = '0;
      nxt_ch_d = '0;
    end

`ifdef DAC_STREAM_IRQ_EN
    intr_d = irq_en_d && (und_d || (level_d <= LVL_W'(FIFO_DEPTH / 4)));
`else
    intr_d = 1'b0;
`endif
  end

  always_ff @(posedge Bus2IP_Clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (Bus2IP_Reset) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      div_q     <= '0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      und_q     <= 1'b0;
      ovf_q     <= 1'b0;
      und_cnt_q <= '0;
      dac_q     <= '0;
      chan_q    <= '0;
      nxt_ch_q  <= '0;
      upd_q     <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      und_q     <= und_d;
      ovf_q     <= ovf_d;
      und_cnt_q <= und_cnt_d;
      dac_q     <= dac_d;
      chan_q    <= chan_d;
      nxt_ch_q  <= nxt_ch_d;
      upd_q     <= upd_d;
      intr_q    <= intr_d;
    end
  end

  // NOTE: the sample array has no reset; empty pointers make its contents unobservable.
  always_ff @(posedge Bus2IP_Clk) begin
    if (push) mem[wr_ptr_q] <= wdata[DAC_WIDTH-1:0];
  end

  always_comb begin
    rdata = '0;
    if (bus.Bus2IP_RdCE[0]) begin
      rdata[0] = en_q;
      rdata[2] = irq_en_q;
    end
    if (bus.Bus2IP_RdCE[1]) rdata[15:0] = div_q;
    if (bus.Bus2IP_RdCE[2]) begin
      rdata[0]          = empty;
      rdata[1]          = full;
      rdata[2]          = und_q;
      rdata[3]          = ovf_q;
      rdata[LVL_W+7:8]  = level_q;
    end
    if (bus.Bus2IP_RdCE[3]) rdata[15:0] = und_cnt_q;
  end

  assign bus.IP2Bus_Data  = rdata;
  assign bus.IP2Bus_RdAck = |bus.Bus2IP_RdCE;
  assign bus.IP2Bus_WrAck = |bus.Bus2IP_WrCE;
  assign bus.IP2Bus_Error = 1'b0;

  assign IP2DAC_Data   = dac_q;
  assign IP2DAC_Chan   = chan_q;
  assign IP2DAC_Update = upd_q;

`ifdef DAC_STREAM_IRQ_EN
  assign IP2Bus_IntrEvent = intr_q;
`endif

  // Byte enables and the upper data half never steer any logic.
  logic unused_bits;
  assign unused_bits = ^{bus.Bus2IP_BE, wdata[31:16], intr_q};

endmodule

// File: tb/tb_plb_dac_stream_ul.sv
// Self-checking bench for plb_dac_stream_ul: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_plb_dac_stream_ul;

  localparam int DAC_WIDTH  = 10;
  localparam int NUM_CH     = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int CH_W       = 1;
  localparam logic [31:0] SMASK = (32'd1 << DAC_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:DAC_WIDTH-1] dac_data;
  logic [0:CH_W-1]      dac_chan;
  logic                 dac_upd;
`ifdef DAC_STREAM_IRQ_EN
  logic                 intr;
`endif

  plb_dac_stream_ul_if bus ();

  plb_dac_stream_ul #(
    .DAC_WIDTH (DAC_WIDTH),
    .NUM_CH    (NUM_CH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .Bus2IP_Clk      (clk),
    .Bus2IP_Reset    (rst),
    .bus             (bus),
    .IP2DAC_Data     (dac_data),
    .IP2DAC_Chan     (dac_chan),
    .IP2DAC_Update   (dac_upd)
`ifdef DAC_STREAM_IRQ_EN
    ,
    .IP2Bus_IntrEvent(intr)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a sample queue plus the externally visible registers.
  int q[$];
  bit m_en, m_irq_en, m_und, m_ovf, m_upd, m_intr;
  int m_div, m_since, m_next, m_chan, m_dac, m_und_cnt;

  task automatic model_reset();
    q.delete();
    m_en = 0; m_irq_en = 0; m_und = 0; m_ovf = 0; m_upd = 0; m_intr = 0;
    m_div = 0; m_since = 0; m_next = 0; m_chan = 0; m_dac = 0; m_und_cnt = 0;
  endtask

  function automatic logic [31:0] model_read(input int ce);
    logic [31:0] v;
    v = '0;
    case (ce)
      0: v = {29'd0, m_irq_en, 1'b0, m_en};
      1: v = m_div;
      2: v = (q.size() << 8) | (m_ovf << 3) | (m_und << 2)
             | ((q.size() == FIFO_DEPTH) << 1) | (q.size() == 0);
      3: v = m_und_cnt;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_edge(input int wr_ce, input logic [31:0] data);
    bit clr, tick;
    clr  = (wr_ce == 0) && data[1];
    tick = m_en && ((m_since % (m_div + 1)) == m_div);
    if (wr_ce == 1 || !m_en) m_since = 0;
    else                     m_since++;
    m_upd = 0;
    if (tick && !clr) begin
      if (q.size() > 0) begin
        m_dac  = q.pop_front();
        m_chan = m_next;
        m_next = (m_next + 1) % NUM_CH;
        m_upd  = 1;
      end else begin
        m_und = 1;
        if (m_und_cnt < 65535) m_und_cnt++;
      end
    end
    if (wr_ce == 2 && !clr) begin
      if (q.size() < FIFO_DEPTH) q.push_back(int'(data & SMASK));
      else                       m_ovf = 1;
    end
    if (wr_ce == 3) begin
      m_und = 0; m_ovf = 0; m_und_cnt = 0;
    end
    if (wr_ce == 0) begin
      if (data[0] && !m_en) m_next = 0;
      m_en     = data[0];
      m_irq_en = data[2];
    end
    if (wr_ce == 1) m_div = int'(data[15:0]);
    if (clr) begin
      q.delete(); m_chan = 0; m_next = 0;
    end
    m_intr = m_irq_en && (m_und || (q.size() <= FIFO_DEPTH / 4));
  endtask

  task automatic check_outputs();
    check("dac_data", dac_data, m_dac);
    check("dac_chan", dac_chan, m_chan);
    check("dac_update", dac_upd, m_upd);
`ifdef DAC_STREAM_IRQ_EN
    check("intr_event", intr, m_intr);
`endif
  endtask

  // One bus cycle: drive, check combinational acks/read data, advance model and DUT.
  task automatic step(input int wr_ce, input int rd_ce, input logic [31:0] data);
    logic [0:3] wv, rv;
    wv = '0;
    rv = '0;
    if (wr_ce >= 0) wv[wr_ce] = 1'b1;
    if (rd_ce >= 0) rv[rd_ce] = 1'b1;
    bus.Bus2IP_WrCE = wv;
    bus.Bus2IP_RdCE = rv;
    bus.Bus2IP_Data = data;
    bus.Bus2IP_BE   = 4'hF;
    #1;
    check("wr_ack", bus.IP2Bus_WrAck, wr_ce >= 0);
    check("rd_ack", bus.IP2Bus_RdAck, rd_ce >= 0);
    check("bus_error", bus.IP2Bus_Error, 0);
    if (rd_ce >= 0) begin
      last_rd = bus.IP2Bus_Data;
      check($sformatf("read_ce%0d", rd_ce), last_rd, model_read(rd_ce));
    end
    model_edge(wr_ce, data);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wr(input int ce, input logic [31:0] d); step(ce, -1, d); endtask
  task automatic rd(input int ce);                       step(-1, ce, 32'd0); endtask
  task automatic idle();                                 step(-1, -1, 32'd0); endtask

  task automatic do_reset();
    bus.Bus2IP_WrCE = '0;
    bus.Bus2IP_RdCE = '0;
    bus.Bus2IP_Data = '0;
    bus.Bus2IP_BE   = 4'hF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("reset_data", dac_data, 0);
    check("reset_chan", dac_chan, 0);
    check("reset_update", dac_upd, 0);
`ifdef DAC_STREAM_IRQ_EN
    check("reset_intr", intr, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulse_cyc[$];
    int pulse_dat[$];
    int pulse_ch[$];
    int n_upd;
    bit seen;
    logic [31:0] d;
    int wce, rce, r;

    // Reset state and register reads.
    do_reset();
    do_reset();
    for (int i = 0; i < 4; i++) rd(i);
    rd(2);
    check("reset_status", last_rd, 32'h1);
    for (int i = 0; i < 3; i++) idle();

    // Four samples at DIV=3 over two channels, then underruns.
    wr(1, 32'd3);
    wr(2, 32'h123);
    wr(2, 32'h0AB);
    wr(2, 32'h3FF);
    wr(2, 32'h001);
    wr(0, 32'h1);
    for (int i = 0; i < 24; i++) begin
      idle();
      if (dac_upd) begin
        pulse_cyc.push_back(i);
        pulse_dat.push_back(int'(dac_data));
        pulse_ch.push_back(int'(dac_chan));
      end
    end
    check("pulse_count", pulse_cyc.size(), 4);
    if (pulse_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("pulse_gap", pulse_cyc[i] - pulse_cyc[i-1], 4);
      check("pulse_data0", pulse_dat[0], 32'h123);
      check("pulse_data1", pulse_dat[1], 32'h0AB);
      check("pulse_data2", pulse_dat[2], 32'h3FF);
      check("pulse_data3", pulse_dat[3], 32'h001);
      for (int i = 0; i < 4; i++) check("pulse_chan", pulse_ch[i], i % 2);
    end
    rd(3);
    check("underrun_count", last_rd, 32'd2);
    check("data_hold", dac_data, 32'h001);

    // Overflow on a full FIFO while disabled, then counter/sticky clear.
    wr(0, 32'h0);
    wr(3, 32'h0);
    for (int i = 0; i < FIFO_DEPTH; i++) wr(2, $urandom);
    wr(2, 32'h155);
    rd(2);
    check("full_status", last_rd, 32'h100A);
    wr(3, 32'hDEAD_BEEF);
    rd(2);
    check("full_after_clear", last_rd, 32'h1002);
    rd(3);
    check("count_after_clear", last_rd, 32'd0);

    // DIV=0 with a push every cycle.
    wr(0, 32'h2);
    wr(1, 32'h0);
    wr(0, 32'h1);
    n_upd = 0;
    for (int i = 0; i < 20; i++) begin
      step(2, (i == 19) ? 2 : -1, $urandom);
      if (dac_upd) n_upd++;
    end
    check("div0_updates", n_upd, 19);
    check("div0_status", last_rd, 32'h104);

    // FIFO_CLR mid-stream restarts the channel sequence.
    wr(1, 32'd15);
    for (int i = 0; i < 6; i++) wr(2, 32'h100 + i);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      idle();
      if (dac_upd) seen = 1;
    end
    check("pre_clr_pop", seen, 1);
    wr(0, 32'h3);
    check("clr_chan", dac_chan, 0);
    rd(2);
    check("clr_level", last_rd & 32'h1F03, 32'h1);
    wr(2, 32'h2AA);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle();
      if (dac_upd) seen = 1;
    end
    check("post_clr_pop", seen, 1);
    check("post_clr_chan", dac_chan, 0);
    check("post_clr_data", dac_data, 32'h2AA);
    for (int i = 0; i < 3; i++) wr(2, $urandom);
    do_reset();

    // Randomized traffic.
    wr(1, 32'd1);
    wr(0, 32'h1);
    for (int n = 0; n < 1500; n++) begin
      r   = $urandom_range(99);
      wce = -1;
      rce = -1;
      d   = $urandom;
      if (r < 55) wce = 2;
      else if (r < 60) begin
        wce = 0;
        d = (d & ~32'h7) | (($urandom_range(7) != 0) ? 32'h1 : 32'h0)
            | (($urandom_range(19) == 0) ? 32'h2 : 32'h0) | ($urandom_range(1) << 2);
      end else if (r < 64) begin
        wce = 1;
        d = (d & 32'hFFFF_0000) | $urandom_range(3);
      end else if (r < 66) wce = 3;
      if ($urandom_range(3) == 0) rce = $urandom_range(3);
      if ($urandom_range(499) == 0) do_reset();
      else step(wce, rce, d);
    end

`ifdef DAC_STREAM_IRQ_EN
    // Low-water interrupt threshold.
    do_reset();
    wr(0, 32'h4);
    for (int i = 0; i < 5; i++) wr(2, $urandom);
    check("irq_level5", intr, 0);
    wr(1, 32'd0);
    wr(0, 32'h5);
    idle();
    check("irq_level4", intr, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
